// File: rtl/reg_out_pkg.sv
// Shared constants and width helpers for the output word packer.
//   Default geometry (WIDTH/N_IN/N_OUT/CNT_W), buffer capacity derivation and
//   the $clog2-based widths of the buffer count and beat fill fields.
package reg_out_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefNIn   = 2;
  localparam int unsigned DefNOut  = 4;
  localparam int unsigned DefCntW  = 16;

  // The buffer must hold a full beat that is still waiting on the consumer
  // plus one maximal input transfer accepted in the same cycle.
  function automatic int unsigned calc_cap(int unsigned n_out, int unsigned n_in);
    return n_out + n_in;
  endfunction

  // Width of the buffer occupancy count (0..CAP).
  function automatic int unsigned cnt_bits(int unsigned n_out, int unsigned n_in);
    return $clog2(calc_cap(n_out, n_in) + 1);
  endfunction

  // Width of the per-beat fill count (0..N_OUT).
  function automatic int unsigned fill_bits(int unsigned n_out);
    return $clog2(n_out + 1);
  endfunction

  localparam int unsigned DefCap      = calc_cap(DefNOut, DefNIn);
  localparam int unsigned DefCntBits  = $clog2(DefCap + 1);
  localparam int unsigned DefFillBits = $clog2(DefNOut + 1);

endpackage

// File: rtl/pack_shift_buf.sv
// Word buffer for the output packer: a shift-down FIFO of CAP words.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_pop_n        : words removed from the head this edge
//   i_push_n       : words appended after the survivors this edge
//   i_push_words   : incoming words, word k at [k*WIDTH +: WIDTH]
//   o_head         : buffer words 0..N_OUT-1, oldest in the low word
//   o_cnt          : number of valid words held
module pack_shift_buf
  import reg_out_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N_IN  = DefNIn,
  parameter int unsigned N_OUT = DefNOut,
  localparam int         Cap   = int'(calc_cap(N_OUT, N_IN)),
  localparam int unsigned CntW = cnt_bits(N_OUT, N_IN)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [CntW-1:0]         i_pop_n,
  input  logic [CntW-1:0]         i_push_n,
  input  logic [N_IN*WIDTH-1:0]   i_push_words,
  output logic [N_OUT*WIDTH-1:0]  o_head,
  output logic [CntW-1:0]         o_cnt
);

  logic [WIDTH-1:0] buf_q [Cap];
  logic [WIDTH-1:0] buf_d [Cap];
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    int rem;
    int pop;
    pop = int'(i_pop_n);
    rem = int'(cnt_q) - pop;
    // Shift survivors down, then append new words right after them.
    for (int i = 0; i < Cap; i++) begin
      if (i + pop < Cap) buf_d[i] = buf_q[i + pop];
      else               buf_d[i] = '0;
    end
    for (int k = 0; k < int'(N_IN); k++) begin
      if (k < int'(i_push_n) && rem + k < Cap) begin
        buf_d[rem + k] = i_push_words[k*WIDTH +: WIDTH];
      end
    end
    cnt_d = CntW'(rem + int'(i_push_n));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
      for (int i = 0; i < Cap; i++) buf_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < Cap; i++) buf_q[i] <= buf_d[i];
    end
  end

  always_comb begin
    o_head = '0;
    for (int j = 0; j < int'(N_OUT); j++) o_head[j*WIDTH +: WIDTH] = buf_q[j];
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/reg_out_pack.sv
// Packs 0..N_IN input words per cycle into N_OUT-word output beats.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_valid/o_ready       : input handshake; i_count words of i_words taken
//   i_flush               : drain request, sampled with o_ready
//   o_valid/i_ready       : output handshake for o_word/o_fill/o_last
//   o_beat_cnt            : beats handshaken since reset (wrapping)
module reg_out_pack
  import reg_out_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N_IN  = DefNIn,
  parameter int unsigned N_OUT = DefNOut,
  parameter int unsigned CNT_W = DefCntW,
  localparam int unsigned CntW  = cnt_bits(N_OUT, N_IN),
  localparam int unsigned FillW = fill_bits(N_OUT),
  localparam int unsigned InW   = $clog2(N_IN + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic [InW-1:0]         i_count,
  input  logic [N_IN*WIDTH-1:0]  i_words,
  input  logic                   i_flush,
  output logic                   o_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [N_OUT*WIDTH-1:0] o_word,
  output logic [FillW-1:0]       o_fill,
  output logic                   o_last,
  output logic [CNT_W-1:0]       o_beat_cnt
);

  logic [N_OUT*WIDTH-1:0] head;
  logic [CntW-1:0]        cnt, pop_n, push_n;
  logic [FillW-1:0]       fill;
  logic [InW-1:0]         n_in;
  logic                   full, nonempty, pop, push;
  logic                   flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;

  pack_shift_buf #(
    .WIDTH (WIDTH),
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_buf (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_pop_n      (pop_n),
    .i_push_n     (push_n),
    .i_push_words (i_words),
    .o_head       (head),
    .o_cnt        (cnt)
  );

  always_comb begin
    full     = cnt >= CntW'(N_OUT);
    nonempty = cnt != '0;
    fill     = full ? FillW'(N_OUT) : FillW'(cnt);
    // Outputs are forced to their idle values while reset is held so the
    // reset state is visible before the first clock edge.
    o_valid  = ~i_reset & (full | (flush_pend_q & nonempty));
    o_last   = ~i_reset & flush_pend_q & (cnt <= CntW'(N_OUT)) & nonempty;
    pop      = o_valid & i_ready;
    // A beat leaving this edge frees room, so accept even above N_OUT.
    o_ready  = i_reset | (~flush_pend_q & ((cnt <= CntW'(N_OUT)) | pop));
    push     = ~i_reset & i_valid & o_ready;
    n_in     = (i_count > InW'(N_IN)) ? InW'(N_IN) : i_count;
    pop_n    = pop  ? CntW'(fill) : '0;
    push_n   = push ? CntW'(n_in) : '0;

    o_fill     = i_reset ? '0 : fill;
    o_beat_cnt = i_reset ? '0 : beat_cnt_q;
    o_word     = '0;
    for (int j = 0; j < int'(N_OUT); j++) begin
      if (!i_reset && CntW'(j) < cnt) o_word[j*WIDTH +: WIDTH] = head[j*WIDTH +: WIDTH];
    end

    // Flush ends on the o_last pop, or at once if nothing was buffered.
    if (flush_pend_q) flush_pend_d = ~((pop & o_last) | ~nonempty);
    else              flush_pend_d = i_flush & o_ready;
    beat_cnt_d = pop ? beat_cnt_q + 1'b1 : beat_cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flush_pend_q <= 1'b0;
      beat_cnt_q   <= '0;
    end else begin
      flush_pend_q <= flush_pend_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_reg_out_pack.sv
module tb_reg_out_pack;

  localparam int unsigned W  = 32;
  localparam int unsigned NI = 2;
  localparam int unsigned NO = 4;
  localparam int unsigned CW = 10;  // short counter so the wrap is reachable quickly

  typedef struct packed {
    logic [127:0] w;
    logic [2:0]   fill;
    logic         last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid, i_flush, i_ready;
  logic [1:0]    i_count;
  logic [63:0]   i_words;
  logic          o_ready, o_valid, o_last;
  logic [127:0]  o_word;
  logic [2:0]    o_fill;
  logic [CW-1:0] o_beat_cnt;

  beat_t exp_q[$];
  int    exp_beats = 0;
  int    n_vec = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  reg_out_pack #(
    .WIDTH (W),
    .N_IN  (NI),
    .N_OUT (NO),
    .CNT_W (CW)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_valid    (i_valid),
    .i_count    (i_count),
    .i_words    (i_words),
    .i_flush    (i_flush),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_word     (o_word),
    .o_fill     (o_fill),
    .o_last     (o_last),
    .o_beat_cnt (o_beat_cnt)
  );

  function automatic beat_t mk(logic [127:0] w, logic [2:0] fill, logic last);
    beat_t b;
    b.w = w;
    b.fill = fill;
    b.last = last;
    return b;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every handshaken beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && o_valid && i_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got word %h fill %0d last %0d, expected no beat",
                 o_word, o_fill, o_last);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        if (o_word !== e.w || o_fill !== e.fill || o_last !== e.last) begin
          n_err++;
          $display("FAIL beat_data: got %h/%0d/%0d expected %h/%0d/%0d",
                   o_word, o_fill, o_last, e.w, e.fill, e.last);
        end
      end
      n_vec++;
      if (o_beat_cnt !== CW'(exp_beats)) begin
        n_err++;
        $display("FAIL beat_cnt: got %0d expected %0d", o_beat_cnt, CW'(exp_beats));
      end
      exp_beats++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(int c, logic [31:0] a, logic [31:0] b, logic f);
    i_valid = (c > 0) || f;
    i_count = 2'(c);
    i_words = {b, a};
    i_flush = f;
  endtask

  task automatic idle();
    i_valid = 1'b0;
    i_count = 2'd0;
    i_words = '0;
    i_flush = 1'b0;
  endtask

  task automatic step(int c, logic [31:0] a, logic [31:0] b, logic f);
    drive(c, a, b, f);
    tick();
    idle();
  endtask

  initial begin
    rst = 1'b1;
    i_ready = 1'b1;
    idle();
    #1;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_ready", 128'(o_ready), 128'(1));
    chk("rst_word", o_word, 128'h0);
    chk("rst_fill", 128'(o_fill), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_valid", 128'(o_valid), 128'(0));
    chk("post_rst_ready", 128'(o_ready), 128'(1));
    chk("post_rst_last", 128'(o_last), 128'(0));
    chk("post_rst_cnt", 128'(o_beat_cnt), 128'(0));

    // Reference-compatible stream.
    exp_q.push_back(mk(128'h44444444_33333333_22222222_11111111, 3'd4, 1'b0));
    step(2, 32'h11111111, 32'h22222222, 1'b0);
    chk("ref_half_valid", 128'(o_valid), 128'(0));
    step(2, 32'h33333333, 32'h44444444, 1'b0);
    chk("ref_valid", 128'(o_valid), 128'(1));
    tick();
    chk("ref_beat_cnt", 128'(o_beat_cnt), 128'(1));

    // Variable counts 1,2,2; E stays behind, then flushed alone.
    exp_q.push_back(mk(128'h0000000D_0000000C_0000000B_0000000A, 3'd4, 1'b0));
    step(1, 32'hA, 32'h0, 1'b0);
    step(2, 32'hB, 32'hC, 1'b0);
    step(2, 32'hD, 32'hE, 1'b0);
    tick();
    chk("var_res_fill", 128'(o_fill), 128'(1));
    chk("var_res_word", o_word, 128'hE);
    exp_q.push_back(mk(128'hE, 3'd1, 1'b1));
    step(0, 32'h0, 32'h0, 1'b1);
    chk("var_flush_ready", 128'(o_ready), 128'(0));
    chk("var_flush_last", 128'(o_last), 128'(1));
    tick();
    chk("var_after_ready", 128'(o_ready), 128'(1));

    // Backpressure with 6 buffered and a pending push.
    i_ready = 1'b0;
    step(2, 32'h10, 32'h11, 1'b0);
    step(2, 32'h12, 32'h13, 1'b0);
    step(2, 32'h14, 32'h15, 1'b0);
    drive(2, 32'h16, 32'h17, 1'b0);
    #1;
    chk("bp_ready_low", 128'(o_ready), 128'(0));
    chk("bp_word", o_word, 128'h00000013_00000012_00000011_00000010);
    tick();
    tick();
    chk("bp_word_held", o_word, 128'h00000013_00000012_00000011_00000010);
    chk("bp_valid_held", 128'(o_valid), 128'(1));
    exp_q.push_back(mk(128'h00000013_00000012_00000011_00000010, 3'd4, 1'b0));
    exp_q.push_back(mk(128'h00000017_00000016_00000015_00000014, 3'd4, 1'b0));
    i_ready = 1'b1;
    #1;
    chk("bp_ready_on_pop", 128'(o_ready), 128'(1));
    tick();
    idle();
    tick();
    chk("bp_drained", 128'(o_valid), 128'(0));

    // Partial flush of 3 words.
    step(2, 32'h1, 32'h2, 1'b0);
    step(1, 32'h3, 32'h0, 1'b0);
    i_ready = 1'b0;
    step(0, 32'h0, 32'h0, 1'b1);
    chk("fp_valid", 128'(o_valid), 128'(1));
    chk("fp_word", o_word, 128'h00000000_00000003_00000002_00000001);
    chk("fp_fill", 128'(o_fill), 128'(3));
    chk("fp_last", 128'(o_last), 128'(1));
    chk("fp_ready", 128'(o_ready), 128'(0));
    exp_q.push_back(mk(128'h00000000_00000003_00000002_00000001, 3'd3, 1'b1));
    i_ready = 1'b1;
    tick();
    chk("fp_after_ready", 128'(o_ready), 128'(1));
    chk("fp_after_valid", 128'(o_valid), 128'(0));

    // Flush with 6 words: push-with-flush includes the last two.
    i_ready = 1'b0;
    step(2, 32'h21, 32'h22, 1'b0);
    step(2, 32'h23, 32'h24, 1'b0);
    step(2, 32'h25, 32'h26, 1'b1);
    chk("f6_first_last", 128'(o_last), 128'(0));
    exp_q.push_back(mk(128'h00000024_00000023_00000022_00000021, 3'd4, 1'b0));
    exp_q.push_back(mk(128'h00000000_00000000_00000026_00000025, 3'd2, 1'b1));
    i_ready = 1'b1;
    tick();
    chk("f6_second_last", 128'(o_last), 128'(1));
    chk("f6_second_fill", 128'(o_fill), 128'(2));
    tick();
    chk("f6_done_ready", 128'(o_ready), 128'(1));

    // Flush of an empty buffer.
    step(0, 32'h0, 32'h0, 1'b1);
    chk("fe_ready_low", 128'(o_ready), 128'(0));
    chk("fe_no_valid", 128'(o_valid), 128'(0));
    tick();
    chk("fe_ready_back", 128'(o_ready), 128'(1));

    // Reset while a flush beat is stalled.
    i_ready = 1'b0;
    step(2, 32'h31, 32'h32, 1'b0);
    step(0, 32'h0, 32'h0, 1'b1);
    chk("rf_stalled", 128'(o_valid), 128'(1));
    rst = 1'b1;
    exp_beats = 0;
    tick();
    rst = 1'b0;
    #1;
    chk("rf_valid", 128'(o_valid), 128'(0));
    chk("rf_cnt", 128'(o_beat_cnt), 128'(0));
    chk("rf_ready", 128'(o_ready), 128'(1));
    i_ready = 1'b1;

    // Beat counter wrap after 2^CW beats.
    for (int b = 0; b < (1 << CW); b++) begin
      logic [31:0] v;
      v = 32'h1000 + 32'(4 * b);
      exp_q.push_back(mk({v + 32'd3, v + 32'd2, v + 32'd1, v}, 3'd4, 1'b0));
    end
    for (int p = 0; p < (2 << CW); p++) begin
      step(2, 32'h1000 + 32'(2 * p), 32'h1001 + 32'(2 * p), 1'b0);
    end
    tick();
    tick();
    chk("wrap_cnt", 128'(o_beat_cnt), 128'(0));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
